// File: rtl/adf4158_ctrl.sv
// adf4158_ctrl: powers up the ADF4158, shifts its ten configuration words over
// the 3-wire bus, then turns MUXOUT rising edges into ramp_start / ramp_on.
module adf4158_ctrl #(
    parameter int unsigned CE_DELAY    = 1000,
    parameter int unsigned RAMP_CYCLES = 40000,
    parameter logic [31:0] R7          = 32'h0000_0007,
    parameter logic [31:0] R6_0        = 32'h0000_0006,
    parameter logic [31:0] R6_1        = 32'h0080_0006,
    parameter logic [31:0] R5_0        = 32'h0000_0005,
    parameter logic [31:0] R5_1        = 32'h0080_0005,
    parameter logic [31:0] R4          = 32'h0018_0104,
    parameter logic [31:0] R3          = 32'h0000_0043,
    parameter logic [31:0] R2          = 32'h0040_800A,
    parameter logic [31:0] R1          = 32'h0000_0001,
    parameter logic [31:0] R0          = 32'h807C_8000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic muxout,
    output logic config_done,
    output logic ce,
    output logic le,
    output logic sclk,
    output logic data,
    output logic txdata,
    output logic ramp_start,
    output logic ramp_on
);

    localparam int unsigned CE_W     = (CE_DELAY > 1) ? $clog2(CE_DELAY) : 1;
    localparam int unsigned RAMP_W   = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int unsigned WORD_W   = 4;
    localparam int unsigned BIT_W    = 5;
    localparam int unsigned N_WORDS  = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CE_WAIT = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_LATCH   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_ce;
    logic                r_le;
    logic                r_sclk;
    logic                r_data;
    logic                r_done;
    logic [CE_W-1:0]     r_ce_cnt;
    logic [WORD_W-1:0]   r_word;
    logic [BIT_W-1:0]    r_bit;
    logic                r_lat;
    logic [31:0]         r_sr;

    logic                r_mux_s1;
    logic                r_mux_s2;
    logic                r_mux_s3;
    logic                r_ramp_start;
    logic                r_ramp_on;
    logic [RAMP_W-1:0]   r_ramp_cnt;

    logic [31:0]         w_word;
    logic                w_mux_rise;
    logic                w_in_done;

    // Word k of the sequence, with the control bits forced to the register index.
    always_comb begin
        w_word = {R0[31:3], 3'd0};
        case (r_word)
            4'd0:    w_word = {R7[31:3],   3'd7};
            4'd1:    w_word = {R6_0[31:3], 3'd6};
            4'd2:    w_word = {R6_1[31:3], 3'd6};
            4'd3:    w_word = {R5_0[31:3], 3'd5};
            4'd4:    w_word = {R5_1[31:3], 3'd5};
            4'd5:    w_word = {R4[31:3],   3'd4};
            4'd6:    w_word = {R3[31:3],   3'd3};
            4'd7:    w_word = {R2[31:3],   3'd2};
            4'd8:    w_word = {R1[31:3],   3'd1};
            default: w_word = {R0[31:3],   3'd0};
        endcase
    end

    // Configuration sequencer; r_sr[31] always mirrors the bit on the data pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ce     <= 1'b0;
            r_le     <= 1'b1;
            r_sclk   <= 1'b0;
            r_data   <= 1'b0;
            r_done   <= 1'b0;
            r_ce_cnt <= '0;
            r_word   <= '0;
            r_bit    <= '0;
            r_lat    <= 1'b0;
            r_sr     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_ce     <= 1'b1;
                        r_ce_cnt <= '0;
                        r_word   <= '0;
                        r_state  <= ST_CE_WAIT;
                    end
                end
                ST_CE_WAIT: begin
                    if (r_ce_cnt == CE_W'(CE_DELAY - 1)) begin
                        r_le    <= 1'b0;
                        r_sr    <= w_word;
                        r_data  <= w_word[31];
                        r_state <= ST_LOAD;
                    end else begin
                        r_ce_cnt <= r_ce_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_sclk  <= 1'b1;
                    r_bit   <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_sclk) begin
                        // Falling half: advance data so it settles before the next rise.
                        r_sclk <= 1'b0;
                        if (r_bit != BIT_W'(31)) begin
                            r_sr   <= {r_sr[30:0], 1'b0};
                            r_data <= r_sr[30];
                        end
                    end else if (r_bit == BIT_W'(31)) begin
                        r_le    <= 1'b1;
                        r_lat   <= 1'b0;
                        r_state <= ST_LATCH;
                    end else begin
                        r_sclk <= 1'b1;
                        r_bit  <= r_bit + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (!r_lat) begin
                        r_lat  <= 1'b1;
                        r_word <= r_word + 1'b1;
                    end else if (r_word == WORD_W'(N_WORDS)) begin
                        r_done  <= 1'b1;
                        r_data  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_le    <= 1'b0;
                        r_sr    <= w_word;
                        r_data  <= w_word[31];
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_in_done  = (r_state == ST_DONE);
    assign w_mux_rise = r_mux_s2 & ~r_mux_s3;

    // MUXOUT synchronizer and ramp window; a fresh edge always reloads the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_s1     <= 1'b0;
            r_mux_s2     <= 1'b0;
            r_mux_s3     <= 1'b0;
            r_ramp_start <= 1'b0;
            r_ramp_on    <= 1'b0;
            r_ramp_cnt   <= '0;
        end else begin
            r_mux_s1     <= muxout;
            r_mux_s2     <= r_mux_s1;
            r_mux_s3     <= r_mux_s2;
            r_ramp_start <= w_mux_rise & w_in_done;
            if (w_mux_rise && w_in_done) begin
                r_ramp_on  <= 1'b1;
                r_ramp_cnt <= RAMP_W'(RAMP_CYCLES - 1);
            end else if (r_ramp_on) begin
                if (r_ramp_cnt == '0) begin
                    r_ramp_on <= 1'b0;
                end else begin
                    r_ramp_cnt <= r_ramp_cnt - 1'b1;
                end
            end
        end
    end

    assign config_done = r_done;
    assign ce          = r_ce;
    assign le          = r_le;
    assign sclk        = r_sclk;
    assign data        = r_data;
    assign txdata      = 1'b0;
    assign ramp_start  = r_ramp_start;
    assign ramp_on     = r_ramp_on;

endmodule

// File: tb/tb_adf4158_ctrl.sv
// tb_adf4158_ctrl: scoreboard bench for adf4158_ctrl; serial words are rebuilt
// from the bus and popped against the expected configuration queue.
module tb_adf4158_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic muxout;
    logic config_done, ce, le, sclk, data, txdata, ramp_start, ramp_on;
    logic config_done_b, ce_b, le_b, sclk_b, data_b, txdata_b, ramp_start_b, ramp_on_b;

    always #5 clk = ~clk;

    adf4158_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .muxout(muxout),
        .config_done(config_done), .ce(ce), .le(le), .sclk(sclk), .data(data),
        .txdata(txdata), .ramp_start(ramp_start), .ramp_on(ramp_on)
    );

    adf4158_ctrl #(.R3(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .muxout(muxout),
        .config_done(config_done_b), .ce(ce_b), .le(le_b), .sclk(sclk_b), .data(data_b),
        .txdata(txdata_b), .ramp_start(ramp_start_b), .ramp_on(ramp_on_b)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_words [10];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] acc_a, acc_b, e_a, e_b;
    int nb_a = 0, nb_b = 0, nwords_a = 0, nwords_b = 0;
    int n_sclk = 0, n_rs = 0, ro_early = 0, viol = 0;
    logic pd = 1'b0;

    wire [7:0] outv   = {ce, le, sclk, data, txdata, config_done, ramp_start, ramp_on};
    wire [7:0] outv_b = {ce_b, le_b, sclk_b, data_b, txdata_b, config_done_b, ramp_start_b, ramp_on_b};

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Rebuild words from dut on sclk rising edges.
    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            nb_a = 0;
        end else begin
            n_sclk++;
            acc_a = {acc_a[30:0], data};
            nb_a++;
            if (nb_a == 32) begin
                nb_a = 0;
                nwords_a++;
                if (q_a.size() == 0) chk("a_extra_word", 32'(q_a.size()), 32'd1);
                else begin
                    e_a = q_a.pop_front();
                    chk("a_word", acc_a, e_a);
                end
            end
        end
    end

    // Rebuild words from dut_b on sclk rising edges.
    always @(posedge sclk_b or negedge rst_n) begin
        if (!rst_n) begin
            nb_b = 0;
        end else begin
            acc_b = {acc_b[30:0], data_b};
            nb_b++;
            if (nb_b == 32) begin
                nb_b = 0;
                nwords_b++;
                if (q_b.size() == 0) chk("b_extra_word", 32'(q_b.size()), 32'd1);
                else begin
                    e_b = q_b.pop_front();
                    chk("b_word", acc_b, e_b);
                end
            end
        end
    end

    // Bus and ramp monitors sampled on the falling clock edge.
    always @(negedge clk) begin
        if (ramp_start) n_rs++;
        if (ramp_on && !config_done) ro_early++;
        if (rst_n && (data !== pd) && sclk) viol++;
        pd = data;
    end

    task automatic push_words();
        for (int k = 0; k < 10; k++) begin
            q_a.push_back(exp_words[k]);
            q_b.push_back((k == 6) ? 32'hFFFF_FFFB : exp_words[k]);
        end
    endtask

    task automatic pulse_enable();
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
    endtask

    task automatic run_config(input bit noisy);
        int n;
        int run;
        push_words();
        pulse_enable();
        chk("ce_on", 32'(ce), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (noisy) muxout = ((n % 7) == 0);
        end while (le && n < 2000);
        muxout = 1'b0;
        chk("ce_to_le", 32'(n), 32'd1000);
        n = 0;
        run = 0;
        do begin
            @(negedge clk);
            n++;
            if (noisy) muxout = (n < 600) && ((n % 11) == 0);
            if (le) run++;
            else begin
                if (run > 0) chk("le_gap", 32'(run), 32'd2);
                run = 0;
            end
        end while (!config_done && n < 2000);
        muxout = 1'b0;
        chk("le_to_done", 32'(n), 32'd670);
        chk("a_nwords", 32'(nwords_a), 32'd10);
        chk("a_q_left", 32'(q_a.size()), 32'd0);
        chk("b_nwords", 32'(nwords_b), 32'd10);
        chk("b_q_left", 32'(q_b.size()), 32'd0);
        chk("b_done", 32'(config_done_b), 32'd1);
        chk("ce_held", 32'(ce), 32'd1);
    endtask

    // One-cycle muxout pulse; ramp_start must appear two edges later.
    task automatic mux_pulse(input string tag);
        @(negedge clk) muxout = 1'b1;
        @(negedge clk) muxout = 1'b0;
        @(negedge clk);
        chk({tag, "_rs_n1"}, 32'(ramp_start), 32'd0);
        @(negedge clk);
        chk({tag, "_rs_n2"}, 32'(ramp_start), 32'd1);
        chk({tag, "_ro_n2"}, 32'(ramp_on), 32'd1);
    endtask

    initial begin
        int n;
        exp_words = '{32'h0000_0007, 32'h0000_0006, 32'h0080_0006, 32'h0000_0005,
                      32'h0080_0005, 32'h0018_0104, 32'h0000_0043, 32'h0040_800A,
                      32'h0000_0001, 32'h807C_8000};
        rst_n  = 1'b0;
        enable = 1'b0;
        muxout = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec", 32'(outv), 32'h40);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_vec", 32'(outv), 32'h40);
        chk("idle_sclk", 32'(n_sclk), 32'd0);

        // Full configuration with muxout noise that must be ignored.
        run_config(1'b1);
        chk("no_rs_cfg", 32'(n_rs), 32'd0);
        chk("no_ro_cfg", 32'(ro_early), 32'd0);
        chk("data_setup_hold", 32'(viol), 32'd0);

        // Ramp window and restart.
        n_rs = 0;
        repeat (5) @(negedge clk);
        mux_pulse("p1");
        repeat (19990) @(negedge clk);
        chk("ro_mid", 32'(ramp_on), 32'd1);
        mux_pulse("p2");
        n = 1;
        do begin
            @(negedge clk);
            if (ramp_on) n++;
        end while (ramp_on && n < 50000);
        chk("ro_len", 32'(n), 32'd40000);
        chk("rs_total", 32'(n_rs), 32'd2);

        // Abort during word 4, then a clean restart from R7.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        nwords_a = 0;
        nwords_b = 0;
        push_words();
        pulse_enable();
        repeat (1000 + 3 * 67 + 20) @(negedge clk);
        chk("abort_nwords", 32'(nwords_a), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_vec", 32'(outv), 32'h40);
        chk("abort_vec_b", 32'(outv_b), 32'h40);
        q_a.delete();
        q_b.delete();
        nwords_a = 0;
        nwords_b = 0;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_config(1'b0);
        chk("data_setup_hold2", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
